// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared types and constants for the fixed-to-float converter
package fpcvt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int SIG_W  = 4;

    localparam logic [DATA_W-1:0] MAG_MAX = 12'h7FF;
    localparam logic [EXP_W-1:0]  E_MAX   = 3'd7;
    localparam logic [SIG_W-1:0]  F_MAX   = 4'hF;
    localparam logic [SIG_W-1:0]  F_ROLL  = 4'h8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant with a registered priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx_w;

    // Scan from the pointer upward, wrapping, and take the first active request.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx_w       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_w = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!any_o && req_i[idx_w]) begin
                any_o       = 1'b1;
                grant_idx_o = idx_w;
            end
        end
        grant_o[grant_idx_o] = any_o;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (int'(grant_idx_o) == NUM_REQ - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpcvt_rr_sequencer.sv
// rtl/fpcvt_rr_sequencer.sv - round-robin shared iterative 12-bit fixed to 3/4 float converter
module fpcvt_rr_sequencer
    import fpcvt_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_sign,
    output logic [EXP_W-1:0]          out_exp,
    output logic [SIG_W-1:0]          out_sig,
    output logic                      busy
);

    state_e state_q, state_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-2:0]  mag;
    logic [SIG_W-1:0]   rnd_f;
    logic [EXP_W-1:0]   rnd_e;

    logic [DATA_W-2:0] s_q, s_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              sign_q, sign_d;
    logic              out_valid_q, out_valid_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [SIG_W-1:0]  out_sig_q, out_sig_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = NORM;
            NORM:    if (s_q[DATA_W-2] || e_q == '0) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state_q == IDLE) && grant_any;
        req_ready = (state_q == IDLE) ? grant : '0;
        busy      = (state_q != IDLE);
    end

    // -32768-style minimum (12'h800) has no positive twin, so it clamps to the largest magnitude.
    always_comb begin
        sel_data = req_data[DATA_W*grant_idx +: DATA_W];
        if (sel_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
            mag = MAG_MAX[DATA_W-2:0];
        end else if (sel_data[DATA_W-1]) begin
            mag = ~sel_data[DATA_W-2:0] + 1'b1;
        end else begin
            mag = sel_data[DATA_W-2:0];
        end
    end

    always_comb begin
        rnd_f = s_q[DATA_W-2 -: SIG_W];
        rnd_e = e_q;
        if (s_q[DATA_W-2-SIG_W]) begin
            if (rnd_f != F_MAX) begin
                rnd_f = rnd_f + 1'b1;
            end else if (e_q != E_MAX) begin
                rnd_f = F_ROLL;
                rnd_e = e_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_d         = s_q;
        e_d         = e_q;
        id_d        = id_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_sig_d   = out_sig_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d   = grant_idx;
                    sign_d = sel_data[DATA_W-1];
                    s_d    = mag;
                    e_d    = E_MAX;
                end
            end
            NORM: begin
                if (!s_q[DATA_W-2] && e_q != '0) begin
                    s_d = s_q << 1;
                    e_d = e_q - 1'b1;
                end
            end
            ROUND: begin
                out_valid_d = 1'b1;
                out_id_d    = id_q;
                out_sign_d  = sign_q;
                out_exp_d   = rnd_e;
                out_sig_d   = rnd_f;
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            e_q         <= '0;
            id_q        <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
        end else begin
            s_q         <= s_d;
            e_q         <= e_d;
            id_q        <= id_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_sig_q   <= out_sig_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_sig   = out_sig_q;

endmodule

// File: tb/tb_fpcvt_rr_sequencer.sv
// tb/tb_fpcvt_rr_sequencer.sv - scoreboard bench for the shared round-robin converter
module tb_fpcvt_rr_sequencer;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [12*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ID_W-1:0]      out_id;
    logic                 out_sign;
    logic [2:0]           out_exp;
    logic [3:0]           out_sig;
    logic                 busy;

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    fpcvt_rr_sequencer #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pk(input int id, input int s, input int e, input int f);
        return {1'(id), 1'(s), 3'(e), 4'(f)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        logic [8:0] ev;
        forever begin
            @(negedge clk);
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none",
                             {out_id, out_sign, out_exp, out_sig});
                end else begin
                    ev = exp_q.pop_front();
                    chk("result", 32'({out_id, out_sign, out_exp, out_sig}), 32'(ev));
                end
            end
        end
    end

    task automatic send(input int idx, input logic [11:0] d, input logic [8:0] ev,
                        input bit push, input int lat);
        int n;
        @(negedge clk);
        req_valid[idx] = 1'b1;
        req_data[12*idx +: 12] = d;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[idx]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back(ev);
        #1;
        req_valid[idx] = 1'b0;
        if (lat > 0) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!out_valid && n < 12);
            chk("latency", 32'(n), 32'(lat));
        end
    endtask

    task automatic grant_seq(input int cnt, input int first, input logic [11:0] d0,
                             input logic [11:0] d1, input logic [8:0] e0, input logic [8:0] e1);
        int gid;
        int acc;
        int guard;
        gid = first;
        acc = 0;
        guard = 0;
        @(negedge clk);
        req_data  = {d1, d0};
        req_valid = 2'b11;
        #1;
        while (acc < cnt && guard < 200) begin
            if (req_ready != '0) begin
                chk("grant_order", 32'(req_ready), 32'(1 << gid));
                exp_q.push_back(gid == 0 ? e0 : e1);
                acc++;
                gid = 1 - gid;
                @(posedge clk);
                #1;
                if (acc == cnt) req_valid = '0;
            end
            @(negedge clk);
            guard++;
        end
        req_valid = '0;
        if (acc < cnt) chk("grant_seq_timeout", 32'(acc), 32'(cnt));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fields", 32'({out_id, out_sign, out_exp, out_sig}), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        send(0, 12'h1A6, pk(0, 0, 5, 4'hD), 1'b1, 4);
        wait_idle();
        send(0, 12'h1F8, pk(0, 0, 6, 4'h8), 1'b1, 4);
        wait_idle();
        send(1, 12'hFC8, pk(1, 1, 2, 4'hE), 1'b1, 7);
        wait_idle();
        send(1, 12'h800, pk(1, 1, 7, 4'hF), 1'b1, 2);
        wait_idle();
        send(1, 12'h000, pk(1, 0, 0, 4'h0), 1'b1, 9);
        wait_idle();

        grant_seq(4, 0, 12'h400, 12'h7FF, pk(0, 0, 7, 4'h8), pk(1, 0, 7, 4'hF));
        wait_idle();

        // Backpressure: result held while requester 1 waits.
        out_ready = 1'b0;
        send(0, 12'h1A6, pk(0, 0, 5, 4'hD), 1'b1, 4);
        req_data[23:12] = 12'h1F8;
        req_valid[1]    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_fields", 32'({out_id, out_sign, out_exp, out_sig}), 32'(pk(0, 0, 5, 4'hD)));
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        exp_q.push_back(pk(1, 0, 6, 4'h8));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Reset while normalising a zero drops the conversion and the pointer.
        send(0, 12'h000, 9'd0, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        grant_seq(2, 0, 12'h1A6, 12'h1F8, pk(0, 0, 5, 4'hD), pk(1, 0, 6, 4'h8));
        wait_idle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
